time_set_register: RTL

Receiving end of the time-setting enable interface. It consumes the one-hot field enables (hour/min/sec) and the completion pulse produced by the setting-sequence FSM, plus keypad digit strobes. It accumulates two-digit decimal entries per field and range-checks the result. On success it commits the time to the registers read by the alarm/nap timer; on failure it rejects the entry.

---
 rtl/time_set_register.sv | 134 +++++++++++++
 1 files changed

// File: rtl/time_set_register.sv
// Time-set register: collects keypad digits into hour/minute/second fields while
// the setting sequence enables them, range-checks on completion and commits the
// result to the registers read by the alarm/nap timer.
module time_set_register #(
   parameter int unsigned HOUR_MAX = 23,
   parameter int unsigned MIN_MAX  = 59,
   parameter int unsigned SEC_MAX  = 59
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hour_en,
   input  logic       min_en,
   input  logic       sec_en,
   input  logic       complete_setting,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       time_valid,
   output logic       range_error,
   output logic       busy
);

   localparam int unsigned HW = 5;
   localparam int unsigned MW = 6;
   localparam int unsigned VW = 7;
   localparam int unsigned NF = 3;

   typedef enum logic [1:0] {IDLE, ENTRY, CHECK} state_t;

   state_t               state;
   logic [NF-1:0][3:0]   tens;
   logic [NF-1:0][3:0]   ones;
   logic [NF-1:0][1:0]   count;

   logic [2:0]           en;
   logic [1:0]           sel;
   logic                 one_hot;
   logic                 key_ok;
   logic [VW-1:0]        hour_val;
   logic [VW-1:0]        min_val;
   logic [VW-1:0]        sec_val;
   logic                 in_range;

   assign en = {hour_en, min_en, sec_en};

   // Decode which single field (0=hour, 1=minute, 2=second) a key targets.
   always_comb begin
      sel     = 2'd0;
      one_hot = 1'b0;
      case (en)
         3'b100: begin sel = 2'd0; one_hot = 1'b1; end
         3'b010: begin sel = 2'd1; one_hot = 1'b1; end
         3'b001: begin sel = 2'd2; one_hot = 1'b1; end
         default: begin sel = 2'd0; one_hot = 1'b0; end
      endcase
   end

   // A key is taken only if it is a decimal digit aimed at exactly one field
   // and is not coincident with the completion pulse.
   assign key_ok = key_valid && (key_digit <= 4'd9) && one_hot && !complete_setting;

   // Two-digit decimal to binary at 7 bits so that 99 is representable and rejected.
   assign hour_val = VW'(tens[0]) * 7'd10 + VW'(ones[0]);
   assign min_val  = VW'(tens[1]) * 7'd10 + VW'(ones[1]);
   assign sec_val  = VW'(tens[2]) * 7'd10 + VW'(ones[2]);

   assign in_range = (hour_val <= VW'(HOUR_MAX)) &&
                     (min_val  <= VW'(MIN_MAX))  &&
                     (sec_val  <= VW'(SEC_MAX));

   // Entry FSM with working digit storage and registered commit/pulse outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tens        <= '0;
         ones        <= '0;
         count       <= '0;
         set_hour    <= '0;
         set_min     <= '0;
         set_sec     <= '0;
         time_valid  <= 1'b0;
         range_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         time_valid  <= 1'b0;
         range_error <= 1'b0;
         case (state)
            IDLE: begin
               if (|en) begin
                  tens  <= '0;
                  ones  <= '0;
                  count <= '0;
                  state <= ENTRY;
                  busy  <= 1'b1;
               end
            end
            ENTRY: begin
               if (complete_setting) begin
                  state <= CHECK;
               end else if (!(|en)) begin
                  // Abort: working digits are dropped at the next entry start.
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (key_ok) begin
                  tens[sel] <= ones[sel];
                  ones[sel] <= key_digit;
                  if (count[sel] != 2'd2) begin
                     count[sel] <= count[sel] + 2'd1;
                  end
               end
            end
            CHECK: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (in_range) begin
                  set_hour   <= HW'(hour_val);
                  set_min    <= MW'(min_val);
                  set_sec    <= MW'(sec_val);
                  time_valid <= 1'b1;
               end else begin
                  range_error <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
